// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router: a DEPTH x (WIDTH+1) FIFO whose
// extra bit tags header bytes so the read side can count packet length and flag its end.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_end
);

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [6:0]     pcnt;
  logic           wr_accept;
  logic           rd_accept;
  logic [WIDTH:0] rd_word;
  logic [6:0]     hdr_len;

  // Extra pointer bit distinguishes "same slot, full" from "same slot, empty".
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A flush cycle swallows any read or write presented alongside it.
  assign wr_accept = write_enb && !full  && !soft_reset;
  assign rd_accept = read_enb  && !empty && !soft_reset;

  assign rd_word = mem[rd_ptr[AW-1:0]];
  // Header bits [7:2] carry the payload length; the parity byte adds one more.
  assign hdr_len = {1'b0, rd_word[7:2]};

  // NOTE: storage has no reset; only the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= '0;
      pcnt     <= '0;
      pkt_end  <= 1'b0;
    end else if (soft_reset) begin
      data_out <= '0;
      pcnt     <= '0;
      pkt_end  <= 1'b0;
    end else begin
      pkt_end <= 1'b0;
      if (rd_accept) begin
        data_out <= rd_word[WIDTH-1:0];
        // A header always reloads, so a truncated packet never reports its end.
        if (rd_word[WIDTH]) begin
          pcnt <= hdr_len + 7'd1;
        end else if (pcnt != 7'd0) begin
          pcnt    <= pcnt - 7'd1;
          pkt_end <= (pcnt == 7'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed scenarios plus random traffic,
// all compared against a queue-based packet model.
module tb_router_fifo;

  typedef struct packed {
    logic       we;
    logic       re;
    logic       lfd;
    logic [7:0] din;
    logic       srst;
  } op_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_end;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {tag, byte}, last read byte, remaining packet bytes.
  logic [8:0] mq[$];
  logic [7:0] m_dout = 8'h00;
  logic       m_pend = 1'b0;
  int         m_pcnt = 0;

  router_fifo #(.DEPTH(16), .WIDTH(8), .AW(4)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty), .pkt_end(pkt_end)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(input logic we, input logic re, input logic lfd,
                             input logic [7:0] din, input logic srst);
    op_t o;
    o.we = we; o.re = re; o.lfd = lfd; o.din = din; o.srst = srst;
    return o;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_dout = 8'h00;
    m_pend = 1'b0;
    m_pcnt = 0;
  endfunction

  // Drive one cycle of stimulus and advance the model by the same rules.
  task automatic step(input op_t o);
    logic       rd_ok, wr_ok;
    logic [8:0] e;
    @(negedge clk);
    write_enb = o.we; read_enb = o.re; lfd_state = o.lfd; data_in = o.din; soft_reset = o.srst;
    @(posedge clk);
    #1;
    if (o.srst) begin
      model_clear();
    end else begin
      rd_ok  = o.re && (mq.size() != 0);
      wr_ok  = o.we && (mq.size() < 16);
      m_pend = 1'b0;
      if (rd_ok) begin
        e = mq.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_pcnt = int'(e[7:2]) + 1;
        else if (m_pcnt > 0) begin
          m_pcnt = m_pcnt - 1;
          m_pend = (m_pcnt == 0);
        end
      end
      if (wr_ok) mq.push_back({o.lfd, o.din});
    end
    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    n_checks += 4;
    if (empty !== 1'b1)      begin n_fail++; $display("FAIL reset empty got=%b exp=1", empty); end
    if (full !== 1'b0)       begin n_fail++; $display("FAIL reset full got=%b exp=0", full); end
    if (data_out !== 8'h00)  begin n_fail++; $display("FAIL reset data_out got=%h exp=00", data_out); end
    if (pkt_end !== 1'b0)    begin n_fail++; $display("FAIL reset pkt_end got=%b exp=0", pkt_end); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_packet();
    op_t        ops[$];
    logic [7:0] exp_seq[5];
    int         pulses;
    logic       exp_e, exp_f;
    exp_seq = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5F};
    pulses = 0;
    ops.push_back(mk(1, 0, 1, 8'h0C, 0));
    ops.push_back(mk(1, 0, 0, 8'hA1, 0));
    ops.push_back(mk(1, 0, 0, 8'hA2, 0));
    ops.push_back(mk(1, 0, 0, 8'hA3, 0));
    ops.push_back(mk(1, 0, 0, 8'h5F, 0));
    for (int i = 0; i < 5; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    ops.push_back(mk(0, 0, 0, 8'h00, 0));
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      exp_e = (mq.size() == 0);
      exp_f = (mq.size() == 16);
      n_checks += 4;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL basic[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL basic[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (full !== exp_f)      begin n_fail++; $display("FAIL basic[%0d] full got=%b exp=%b", i, full, exp_f); end
      if (pkt_end !== m_pend)  begin n_fail++; $display("FAIL basic[%0d] pkt_end got=%b exp=%b", i, pkt_end, m_pend); end
      if (i >= 5 && i < 10) begin
        n_checks++;
        if (data_out !== exp_seq[i-5]) begin n_fail++; $display("FAIL basic seq[%0d] got=%h exp=%h", i-5, data_out, exp_seq[i-5]); end
      end
      if (pkt_end === 1'b1) pulses++;
    end
    n_checks += 2;
    if (pulses != 1)     begin n_fail++; $display("FAIL basic pkt_end pulses got=%0d exp=1", pulses); end
    if (empty !== 1'b1)  begin n_fail++; $display("FAIL basic final empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill_full();
    op_t  ops[$];
    logic exp_e, exp_f;
    for (int i = 0; i < 16; i++) ops.push_back(mk(1, 0, 0, 8'(i), 0));
    ops.push_back(mk(1, 0, 0, 8'hFF, 0));
    for (int i = 0; i < 17; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      exp_e = (mq.size() == 0);
      exp_f = (mq.size() == 16);
      n_checks += 4;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL fill[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL fill[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (full !== exp_f)      begin n_fail++; $display("FAIL fill[%0d] full got=%b exp=%b", i, full, exp_f); end
      if (pkt_end !== m_pend)  begin n_fail++; $display("FAIL fill[%0d] pkt_end got=%b exp=%b", i, pkt_end, m_pend); end
      if (i == 15 || i == 16) begin
        n_checks++;
        if (full !== 1'b1) begin n_fail++; $display("FAIL fill full_after_write[%0d] got=%b exp=1", i, full); end
      end
      if (i >= 17 && i < 33) begin
        n_checks++;
        if (data_out !== 8'(i - 17)) begin n_fail++; $display("FAIL fill order[%0d] got=%h exp=%h", i-17, data_out, 8'(i-17)); end
      end
    end
  endtask

  task automatic test_wrap();
    op_t  ops[$];
    logic exp_e;
    for (int i = 0; i < 10; i++) ops.push_back(mk(1, 0, 0, 8'h30 + 8'(i), 0));
    for (int i = 0; i < 10; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    for (int i = 0; i < 12; i++) ops.push_back(mk(1, 0, 0, 8'h60 + 8'(i), 0));
    for (int i = 0; i < 12; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      exp_e = (mq.size() == 0);
      n_checks += 3;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL wrap[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL wrap[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (full !== 1'b0)       begin n_fail++; $display("FAIL wrap[%0d] full got=%b exp=0", i, full); end
    end
  endtask

  task automatic test_simultaneous();
    op_t  ops[$];
    logic exp_e, exp_f;
    for (int i = 0; i < 16; i++) ops.push_back(mk(1, 0, 0, 8'h80 + 8'(i), 0));
    ops.push_back(mk(1, 1, 0, 8'hEE, 0));                    // full: read only
    for (int i = 0; i < 15; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    ops.push_back(mk(1, 1, 0, 8'hC3, 0));                    // empty: write only
    for (int i = 0; i < 4; i++) ops.push_back(mk(1, 0, 0, 8'hD0 + 8'(i), 0));
    for (int i = 0; i < 3; i++) ops.push_back(mk(1, 1, 0, 8'hE0 + 8'(i), 0));
    for (int i = 0; i < 6; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      exp_e = (mq.size() == 0);
      exp_f = (mq.size() == 16);
      n_checks += 4;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL simul[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL simul[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (full !== exp_f)      begin n_fail++; $display("FAIL simul[%0d] full got=%b exp=%b", i, full, exp_f); end
      if (pkt_end !== m_pend)  begin n_fail++; $display("FAIL simul[%0d] pkt_end got=%b exp=%b", i, pkt_end, m_pend); end
      if (i == 16) begin
        n_checks += 2;
        if (full !== 1'b0)       begin n_fail++; $display("FAIL simul full_rw full got=%b exp=0", full); end
        if (data_out !== 8'h80)  begin n_fail++; $display("FAIL simul full_rw data_out got=%h exp=80", data_out); end
      end
      if (i == 32) begin
        n_checks += 2;
        if (empty !== 1'b0)      begin n_fail++; $display("FAIL simul empty_rw empty got=%b exp=0", empty); end
        if (data_out !== 8'h8F)  begin n_fail++; $display("FAIL simul empty_rw data_out got=%h exp=8F", data_out); end
      end
    end
  endtask

  task automatic test_soft_reset();
    op_t  ops[$];
    int   pulses;
    logic exp_e;
    pulses = 0;
    ops.push_back(mk(1, 0, 1, 8'h10, 0));                    // header, 4 payload
    for (int i = 0; i < 4; i++) ops.push_back(mk(1, 0, 0, 8'hB0 + 8'(i), 0));
    ops.push_back(mk(1, 0, 0, 8'h77, 0));
    ops.push_back(mk(0, 1, 0, 8'h00, 0));
    ops.push_back(mk(0, 1, 0, 8'h00, 0));
    ops.push_back(mk(1, 1, 0, 8'h99, 1));                    // flush with discarded r/w
    ops.push_back(mk(0, 0, 0, 8'h00, 0));
    ops.push_back(mk(1, 0, 1, 8'h08, 0));                    // header, 2 payload
    ops.push_back(mk(1, 0, 0, 8'hC1, 0));
    ops.push_back(mk(1, 0, 0, 8'hC2, 0));
    ops.push_back(mk(1, 0, 0, 8'h3C, 0));
    for (int i = 0; i < 5; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    for (int i = 0; i < ops.size(); i++) begin
      step(ops[i]);
      exp_e = (mq.size() == 0);
      n_checks += 3;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL soft[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL soft[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (pkt_end !== m_pend)  begin n_fail++; $display("FAIL soft[%0d] pkt_end got=%b exp=%b", i, pkt_end, m_pend); end
      if (i == 8) begin
        n_checks += 2;
        if (empty !== 1'b1)     begin n_fail++; $display("FAIL soft flush empty got=%b exp=1", empty); end
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL soft flush data_out got=%h exp=00", data_out); end
      end
      if (pkt_end === 1'b1) begin
        pulses++;
        n_checks++;
        if (data_out !== 8'h3C) begin n_fail++; $display("FAIL soft pkt_end_align data_out got=%h exp=3C", data_out); end
      end
    end
    n_checks++;
    if (pulses != 1) begin n_fail++; $display("FAIL soft pkt_end pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_async_reset();
    op_t  ops[$];
    logic exp_e;
    ops.push_back(mk(1, 0, 1, 8'h0C, 0));
    for (int i = 0; i < 4; i++) ops.push_back(mk(1, 0, 0, 8'h41 + 8'(i), 0));
    ops.push_back(mk(1, 0, 1, 8'h04, 0));
    ops.push_back(mk(1, 0, 0, 8'h51, 0));
    for (int i = 0; i < 5; i++) ops.push_back(mk(0, 1, 0, 8'h00, 0));
    for (int i = 0; i < ops.size(); i++) step(ops[i]);
    n_checks += 2;
    if (pkt_end !== 1'b1)   begin n_fail++; $display("FAIL async pre pkt_end got=%b exp=1", pkt_end); end
    if (data_out !== 8'h44) begin n_fail++; $display("FAIL async pre data_out got=%h exp=44", data_out); end
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    n_checks += 4;
    if (empty !== 1'b1)     begin n_fail++; $display("FAIL async empty got=%b exp=1", empty); end
    if (full !== 1'b0)      begin n_fail++; $display("FAIL async full got=%b exp=0", full); end
    if (pkt_end !== 1'b0)   begin n_fail++; $display("FAIL async pkt_end got=%b exp=0", pkt_end); end
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL async data_out got=%h exp=00", data_out); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 1, 0, 8'h00, 0));
      exp_e = (mq.size() == 0);
      n_checks += 3;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL async post[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL async post[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (pkt_end !== m_pend)  begin n_fail++; $display("FAIL async post[%0d] pkt_end got=%b exp=%b", i, pkt_end, m_pend); end
    end
  endtask

  task automatic test_random();
    op_t  o;
    logic exp_e, exp_f;
    for (int i = 0; i < 600; i++) begin
      o.we   = ($urandom_range(0, 3) != 0);
      o.re   = ($urandom_range(0, 2) != 0);
      o.lfd  = ($urandom_range(0, 5) == 0);
      o.din  = 8'($urandom_range(0, 255));
      o.srst = ($urandom_range(0, 79) == 0);
      step(o);
      exp_e = (mq.size() == 0);
      exp_f = (mq.size() == 16);
      n_checks += 4;
      if (data_out !== m_dout) begin n_fail++; $display("FAIL rand[%0d] data_out got=%h exp=%h", i, data_out, m_dout); end
      if (empty !== exp_e)     begin n_fail++; $display("FAIL rand[%0d] empty got=%b exp=%b", i, empty, exp_e); end
      if (full !== exp_f)      begin n_fail++; $display("FAIL rand[%0d] full got=%b exp=%b", i, full, exp_f); end
      if (pkt_end !== m_pend)  begin n_fail++; $display("FAIL rand[%0d] pkt_end got=%b exp=%b", i, pkt_end, m_pend); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_fill_full();
    test_wrap();
    test_simultaneous();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output buffer of the 1x3 router, directly downstream of router_sync.
- One instance per port, three in total. write_enb[i] and soft_reset_i from router_sync drive instance i; full/empty from instance i return to router_sync as full_i/empty_i.
- Stores header, payload and parity bytes, tagging each header byte so the read side can track packet length and report end-of-packet.

Parameters:
- DEPTH, 16, number of storage words (power of two).
- WIDTH, 8, data byte width.
- AW, 4, address width, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- soft_reset  in  1  synchronous flush from router_sync (read timeout); active-high.
- write_enb  in  1  write strobe for this FIFO.
- read_enb  in  1  read strobe from the destination.
- lfd_state  in  1  marks the current data_in byte as a packet header.
- data_in  in  WIDTH  byte to store.
- data_out  out  WIDTH  registered read data.
- full  out  1  all DEPTH words occupied.
- empty  out  1  no words occupied.
- pkt_end  out  1  one-cycle pulse: the last byte (parity) of a packet was presented on data_out.

Behaviour:
- Storage: DEPTH words of WIDTH+1 bits; bit WIDTH holds lfd_state captured at write.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low AW bits are equal.
  - Both flags are combinational from the registered pointers.
- Write is accepted when write_enb && !full: store {lfd_state, data_in} at wr_ptr[AW-1:0], then wr_ptr+1. A write while full is dropped and no state changes.
- Read is accepted when read_enb && !empty: data_out <= stored byte at rd_ptr next edge (1-cycle latency), then rd_ptr+1. A read while empty is ignored and data_out holds its value.
- Simultaneous read and write:
  - Both are accepted if their own conditions hold; occupancy is unchanged.
  - When full, only the read occurs.
  - When empty, only the write occurs; no same-cycle bypass.
- Pointer wrap: the low AW bits wrap modulo DEPTH and the MSB toggles. Both pointers wrap independently.
- Packet counter pcnt (7 bits):
  - On an accepted read of a word with tag=1: pcnt <= data[7:2] + 1, i.e. payload length plus parity byte.
  - On an accepted read of a word with tag=0 and pcnt>0: pcnt <= pcnt-1.
  - pkt_end pulses high in the cycle after an accepted read that changes pcnt from 1 to 0, aligned with data_out showing the parity byte.
  - A tag=0 read with pcnt==0 (stray data) leaves pcnt at 0 and does not pulse pkt_end.
- Header arriving while pcnt>0 (truncated previous packet): the header reload takes priority. pkt_end does not pulse for the truncated packet.
- soft_reset (synchronous, effective at the next edge; ignored while reset is high):
  - wr_ptr, rd_ptr and pcnt are cleared to 0; data_out, pkt_end are driven to 0.
  - Storage contents are not cleared.
  - A write or read in the same cycle as soft_reset is discarded.
- reset (asynchronous, highest priority): wr_ptr=0, rd_ptr=0, pcnt=0, data_out=0, pkt_end=0, so empty=1, full=0. Reset mid-packet discards all stored data; no pkt_end follows release.
- Reset values of outputs: data_out=0, full=0, empty=1, pkt_end=0.
- No tristate outputs; data_out holds its value between reads.

Test Plan:
- Reset and basic read:
  - Assert reset for 2 cycles; check empty=1, full=0, data_out=0.
  - Write header 0x0C (payload length 3) with lfd_state=1, payload 0xA1,0xA2,0xA3, then parity 0x5F.
  - Read 5 times; check data_out sequence 0x0C,0xA1,0xA2,0xA3,0x5F with 1-cycle latency.
  - Check a single pkt_end pulse aligned with 0x5F and empty=1 afterwards.
- Fill to full:
  - Write 16 bytes 0x00..0x0F; check full=1 after the 16th.
  - Write a 17th byte 0xFF; verify it is dropped.
  - Read all 16; check data_out 0x00..0x0F in order and empty=1.
- Wrap-around:
  - Write 10 bytes, read 10, write 12, read 12; check order and data are preserved across the pointer wrap.
  - Check full never asserts during the sequence.
- Simultaneous read/write:
  - With 16 stored, assert read_enb and write_enb together; check only the read occurs and occupancy becomes 15.
  - With 0 stored, assert both; check the byte is stored and data_out is unchanged.
  - With 5 stored, assert both for 3 cycles; check occupancy stays 5.
- Soft reset:
  - Write a 6-byte packet and read 2 bytes.
  - Pulse soft_reset one cycle; check empty=1, data_out=0 and no pkt_end.
  - Then check a new packet reads out correctly with pkt_end on its parity byte.
- Async reset mid-operation:
  - Assert reset between clock edges during reads.
  - Check outputs clear immediately: empty=1, pkt_end=0, data_out=0.
